vector_mem_sequencer: RTL



---
 rtl/vmem_pkg.sv | 28 ++
 rtl/vector_mem_sequencer_if.sv | 33 +++
 rtl/vmem_addr_gen.sv | 46 ++++
 rtl/vector_mem_sequencer.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/vmem_pkg.sv
// Shared types and helpers for the vector memory sequencer.
package vmem_pkg;

    localparam int unsigned VMEM_LANES   = 4;
    localparam int unsigned VMEM_DW      = 8;
    localparam int unsigned VMEM_AW      = 16;
    localparam int unsigned VMEM_MAX_VEC = 1024;
    localparam int unsigned VMEM_MAX_DW  = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } vmem_state_t;

    // Extract lane idx of width dw from a (zero-extended) packed vector.
    function automatic logic [VMEM_MAX_DW-1:0] lane_slice(
        input logic [VMEM_MAX_VEC-1:0] vec,
        input int unsigned             idx,
        input int unsigned             dw
    );
        logic [VMEM_MAX_VEC-1:0] shifted;
        shifted = vec >> (idx * dw);
        return shifted[VMEM_MAX_DW-1:0] & ((VMEM_MAX_DW'(1) << dw) - VMEM_MAX_DW'(1));
    endfunction

endpackage

// File: rtl/vector_mem_sequencer_if.sv
// Request / memory / result bundle of the vector memory sequencer.
interface vector_mem_sequencer_if
    import vmem_pkg::*;
#(
    parameter int unsigned LANES = VMEM_LANES,
    parameter int unsigned DW    = VMEM_DW,
    parameter int unsigned AW    = VMEM_AW
) ();

    logic                  rmem_i;
    logic                  wmem_i;
    logic [AW-1:0]         base_addr;
    logic [AW-1:0]         stride;
    logic [LANES*DW-1:0]   wdata_vec;
    logic [DW-1:0]         mem_rdata;
    logic [AW-1:0]         mem_addr;
    logic                  mem_we;
    logic [DW-1:0]         mem_wdata;
    logic [LANES*DW-1:0]   rdata_vec;
    logic                  stall;
    logic                  done;

    modport master (
        output rmem_i, wmem_i, base_addr, stride, wdata_vec, mem_rdata,
        input  mem_addr, mem_we, mem_wdata, rdata_vec, stall, done
    );

    modport slave (
        input  rmem_i, wmem_i, base_addr, stride, wdata_vec, mem_rdata,
        output mem_addr, mem_we, mem_wdata, rdata_vec, stall, done
    );

endinterface

// File: rtl/vmem_addr_gen.sv
// Lane address accumulator: loaded with the base, steps by stride (VMEM_STRIDE_EN) or by 1.
module vmem_addr_gen #(
    parameter int unsigned AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] stride,
    output logic [AW-1:0] addr
);

    logic [AW-1:0] inc;

`ifdef VMEM_STRIDE_EN
    logic [AW-1:0] stride_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stride_q <= '0;
        end else if (load) begin
            stride_q <= stride;
        end
    end

    assign inc = stride_q;
`else
    logic unused_stride;

    assign unused_stride = ^stride;
    assign inc           = AW'(1);
`endif

    // Address wraps modulo 2^AW.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
        end else if (load) begin
            addr <= base;
        end else if (step) begin
            addr <= addr + inc;
        end
    end

endmodule

// File: rtl/vector_mem_sequencer.sv
// Moves one vector register to/from byte-lane memory, one lane per cycle.
// Lane step is the latched stride when VMEM_STRIDE_EN is defined, otherwise 1.
module vector_mem_sequencer
    import vmem_pkg::*;
#(
    parameter int unsigned LANES = VMEM_LANES,
    parameter int unsigned DW    = VMEM_DW,
    parameter int unsigned AW    = VMEM_AW
) (
    input  logic                  clk,
    input  logic                  rst,
    vector_mem_sequencer_if.slave bus
);

    localparam int unsigned CW = $clog2(LANES);
    localparam int unsigned VW = LANES * DW;

    vmem_state_t   state;
    vmem_state_t   state_nx;

    logic [CW-1:0] k;
    logic          op_store;
    logic [VW-1:0] wvec_q;
    logic          mem_we_q;
    logic [DW-1:0] mem_wdata_q;
    logic [VW-1:0] rdata_q;
    logic          done_q;

    logic          req_c;
    logic          last_c;
    logic          start_c;
    logic          step_c;
    logic          cap_en_c;
    logic [CW-1:0] cap_idx_c;
    logic          stall_c;

    assign req_c  = bus.rmem_i | bus.wmem_i;
    assign last_c = (k == CW'(LANES - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_c) state_nx = RUN;
            RUN:     if (last_c) state_nx = op_store ? DONE : WAIT;
            WAIT:    state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Per-state control strobes; a load captures lane k-1 one cycle behind its address.
    always_comb begin
        start_c   = 1'b0;
        step_c    = 1'b0;
        cap_en_c  = 1'b0;
        cap_idx_c = k - CW'(1);
        stall_c   = 1'b0;
        case (state)
            IDLE: begin
                start_c = req_c;
                stall_c = req_c;
            end
            RUN: begin
                stall_c  = 1'b1;
                step_c   = ~last_c;
                cap_en_c = ~op_store & (k != '0);
            end
            WAIT: begin
                stall_c   = 1'b1;
                cap_en_c  = 1'b1;
                cap_idx_c = CW'(LANES - 1);
            end
            default: ;
        endcase
    end

    // Datapath: request latch, lane counter, store data and load assembly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k           <= '0;
            op_store    <= 1'b0;
            wvec_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= (state_nx == DONE);
            if (start_c) begin
                k        <= '0;
                op_store <= bus.wmem_i;
                wvec_q   <= bus.wdata_vec;
                mem_we_q <= bus.wmem_i;
                if (bus.wmem_i) begin
                    mem_wdata_q <= DW'(lane_slice(VMEM_MAX_VEC'(bus.wdata_vec), 0, DW));
                end
            end
            if (state == RUN) begin
                k <= last_c ? '0 : k + CW'(1);
                if (op_store) begin
                    if (last_c) begin
                        mem_we_q <= 1'b0;
                    end else begin
                        mem_wdata_q <= DW'(lane_slice(VMEM_MAX_VEC'(wvec_q), 32'(k) + 32'd1, DW));
                    end
                end
            end
            if (cap_en_c) begin
                rdata_q[32'(cap_idx_c) * DW +: DW] <= bus.mem_rdata;
            end
        end
    end

    vmem_addr_gen #(
        .AW (AW)
    ) u_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .load   (start_c),
        .step   (step_c),
        .base   (bus.base_addr),
        .stride (bus.stride),
        .addr   (bus.mem_addr)
    );

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rdata_vec = rdata_q;
    assign bus.done      = done_q;
    assign bus.stall     = stall_c & ~rst;

endmodule
